// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART Tx core between three message sources.
// Whole-message grants, round-robin between messages, watchdog reclaim.
module uart_tx_arbiter #(
    parameter int TIMEOUT = 2_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] reqEn,
    input  logic [7:0] reqData0,
    input  logic [7:0] reqData1,
    input  logic [7:0] reqData2,
    output logic [2:0] reqBusy,
    output logic [2:0] reqDone,
    input  logic       coreBusy,
    input  logic       coreDone,
    output logic       txEn,
    output logic [7:0] data,
    output logic [2:0] grant,
    output logic       timeoutErr
);

    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [WW-1:0] WDT_LAST = WW'(TIMEOUT - 1);
    localparam logic [WW-1:0] WDT_MAX  = {WW{1'b1}};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [2:0]    grant_nxt;
    logic [1:0]    ptr, ptr_nxt;
    logic [WW-1:0] wdt, wdt_nxt;
    logic          to_nxt;
    logic [1:0]    g;
    logic [1:0]    g_succ;
    logic          in_grant;

    // First requester at or after position p, searching p, p+1, p+2 mod 3.
    function automatic logic [2:0] pick(input logic [2:0] req,
                                        input logic [1:0] p);
        logic [2:0] sel;
        int         idx;
        sel = 3'b000;
        for (int k = 2; k >= 0; k--) begin
            idx = (int'(p) + k) % 3;
            if (req[idx]) begin
                sel = 3'b001 << idx;
            end
        end
        return sel;
    endfunction

    // Index of the current owner and the requester after it.
    always_comb begin
        g = 2'd0;
        if (grant[2]) begin
            g = 2'd2;
        end else if (grant[1]) begin
            g = 2'd1;
        end
        g_succ = (g == 2'd2) ? 2'd0 : g + 2'd1;
    end

    // Next-state logic: grant, release and watchdog.
    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        ptr_nxt   = ptr;
        wdt_nxt   = wdt;
        to_nxt    = 1'b0;
        unique case (state)
            IDLE: begin
                if (reqEn != 3'b000 && !coreBusy) begin
                    grant_nxt = pick(reqEn, ptr);
                    wdt_nxt   = '0;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (!reqEn[g]) begin
                    state_nxt = RELEASE;
                    ptr_nxt   = g_succ;
                end else if (wdt == WDT_LAST && !coreDone) begin
                    state_nxt = RELEASE;
                    ptr_nxt   = g_succ;
                    to_nxt    = 1'b1;
                end else if (coreDone) begin
                    wdt_nxt = '0;
                end else if (wdt != WDT_MAX) begin
                    wdt_nxt = wdt + 1'b1;
                end
            end
            RELEASE: begin
                if (!coreBusy) begin
                    grant_nxt = 3'b000;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = 3'b000;
            end
        endcase
    end

    // Registered arbiter state and the timeout pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= 3'b000;
            ptr        <= 2'd0;
            wdt        <= '0;
            timeoutErr <= 1'b0;
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            ptr        <= ptr_nxt;
            wdt        <= wdt_nxt;
            timeoutErr <= to_nxt;
        end
    end

    // Core-side and requester-side muxing from the registered owner.
    always_comb begin
        in_grant = (state == GRANT);
        txEn     = in_grant & |(reqEn & grant);
        data     = 8'h00;
        if (in_grant) begin
            unique case (g)
                2'd1:    data = reqData1;
                2'd2:    data = reqData2;
                default: data = reqData0;
            endcase
        end
        reqDone = {3{coreDone & in_grant}} & grant;
        if (state == IDLE) begin
            reqBusy = {3{coreBusy}};
        end else begin
            reqBusy = (grant & {3{coreBusy}}) | ~grant;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: random requesters and core model against a
// message-level reference of the arbitration rules.
module tb_uart_tx_arbiter;

    localparam int T = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] reqEn;
    logic [7:0] rd [3];
    logic [2:0] reqBusy, reqDone, grant;
    logic       coreBusy, coreDone, txEn, timeoutErr;
    logic [7:0] data;

    uart_tx_arbiter #(.TIMEOUT(T)) dut (
        .clk(clk), .rst(rst), .reqEn(reqEn),
        .reqData0(rd[0]), .reqData1(rd[1]), .reqData2(rd[2]),
        .reqBusy(reqBusy), .reqDone(reqDone),
        .coreBusy(coreBusy), .coreDone(coreDone),
        .txEn(txEn), .data(data), .grant(grant),
        .timeoutErr(timeoutErr)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // reference: owner -1 means no owner; rel means draining the core
    int  owner = -1;
    bit  rel = 0;
    int  nxt = 0;
    int  wd = 0;
    bit  m_to = 0;

    // core model
    int  cnt = 0;
    bit  nodone = 0;

    // requester models
    bit  act [3];
    bit  pend [3];
    bit  early [3];
    int  rem [3];

    logic [2:0] e_grant, e_done, e_busy;
    logic       e_tx;
    logic [7:0] e_data;

    int         cyc = 0;
    int         ref_c = 0;
    int         n_to = 0;
    logic [2:0] prev_grant = 3'b000;
    bit         after_rst = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_grant"}, 32'(grant), 0);
        check({tag, "_txEn"}, 32'(txEn), 0);
        check({tag, "_data"}, 32'(data), 0);
        check({tag, "_reqDone"}, 32'(reqDone), 0);
        check({tag, "_timeoutErr"}, 32'(timeoutErr), 0);
        check({tag, "_reqBusy"}, 32'(reqBusy), 32'({3{coreBusy}}));
    endtask

    task automatic compute_expected();
        bit ing;
        ing     = (owner >= 0) && !rel;
        e_grant = (owner >= 0) ? 3'(1 << owner) : 3'b000;
        e_tx    = 1'b0;
        e_data  = 8'h00;
        if (ing) begin
            e_tx   = reqEn[owner];
            e_data = rd[owner];
        end
        e_done = (ing && coreDone) ? e_grant : 3'b000;
        for (int i = 0; i < 3; i++) begin
            e_busy[i] = (owner < 0 || owner == i) ? coreBusy : 1'b1;
        end
    endtask

    task automatic model_edge();
        bit to_n;
        to_n = 0;
        if (owner < 0) begin
            if (reqEn != 3'b000 && !coreBusy) begin
                for (int k = 0; k < 3; k++) begin
                    if (owner < 0 && reqEn[(nxt + k) % 3]) begin
                        owner = (nxt + k) % 3;
                    end
                end
                wd = 0;
            end
        end else if (!rel) begin
            if (!reqEn[owner]) begin
                rel = 1;
                nxt = (owner + 1) % 3;
            end else if (wd == T - 1 && !coreDone) begin
                rel  = 1;
                nxt  = (owner + 1) % 3;
                to_n = 1;
            end else if (coreDone) begin
                wd = 0;
            end else begin
                wd++;
            end
        end else if (!coreBusy) begin
            owner = -1;
            rel   = 0;
        end
        m_to = to_n;
    endtask

    // one clock cycle, entered and left at the falling edge
    task automatic cycle_step(input bit do_rst);
        rst      = 1'b0;
        coreBusy = (cnt > 0);
        coreDone = (cnt == 1) && !nodone;
        for (int i = 0; i < 3; i++) begin
            if (pend[i]) begin
                act[i]  = 0;
                pend[i] = 0;
            end else if (!act[i] && $urandom_range(7) == 0) begin
                act[i]   = 1;
                rem[i]   = $urandom_range(3, 1);
                early[i] = 1'($urandom_range(1));
                rd[i]    = 8'($urandom);
            end
            if (act[i] && owner == i && !rel && coreDone) begin
                rem[i]--;
                if (rem[i] == 0) begin
                    if (early[i]) act[i] = 0;
                    else pend[i] = 1;
                end else begin
                    rd[i] = 8'($urandom);
                end
            end
        end
        reqEn = {act[2], act[1], act[0]};
        #1;
        compute_expected();
        check("grant", 32'(grant), 32'(e_grant));
        check("txEn", 32'(txEn), 32'(e_tx));
        check("data", 32'(data), 32'(e_data));
        check("reqDone", 32'(reqDone), 32'(e_done));
        check("reqBusy", 32'(reqBusy), 32'(e_busy));
        check("timeoutErr", 32'(timeoutErr), 32'(m_to));
        if (after_rst && coreBusy) check("rst_hold", 32'(grant), 0);
        else after_rst = 0;
        if (grant != 3'b000 && prev_grant == 3'b000) ref_c = cyc;
        if (timeoutErr) begin
            check("wdt_delay", 32'(cyc - ref_c), 32'(T));
            n_to++;
        end
        if (|reqDone) ref_c = cyc + 1;
        prev_grant = grant;
        cyc++;
        if (do_rst) begin
            #1 rst = 1'b1;
            #1 check_reset_outputs("rst_mid");
            owner = -1; rel = 0; nxt = 0; wd = 0; m_to = 0;
            e_tx = 1'b0;
            after_rst = 1;
            prev_grant = 3'b000;
        end
        @(posedge clk);
        if (!rst) model_edge();
        if (cnt > 0) begin
            cnt--;
            if (cnt == 0) nodone = 0;
        end else if (e_tx) begin
            if ($urandom_range(11) == 0) begin
                cnt    = 30;
                nodone = 1;
            end else begin
                cnt = $urandom_range(5, 2);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        int guard;
        rst      = 1'b1;
        reqEn    = 3'b000;
        coreBusy = 1'b0;
        coreDone = 1'b0;
        for (int i = 0; i < 3; i++) begin
            act[i] = 0; pend[i] = 0; early[i] = 0; rem[i] = 0;
            rd[i] = 8'h00;
        end
        @(negedge clk);
        check_reset_outputs("por");
        for (int n = 0; n < 4000; n++) cycle_step(0);
        guard = 0;
        while (!(owner >= 0 && !rel && cnt > 0 && !nodone)
               && guard < 500) begin
            cycle_step(0);
            guard++;
        end
        check("mid_msg_found", 32'(guard < 500), 1);
        cycle_step(1);
        for (int n = 0; n < 1000; n++) cycle_step(0);
        check("timeouts_seen", 32'(n_to > 0), 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one UART Tx core between three message sources: the RTC time-string formatter, the command echo path and the error/status message path. Each source drives a level-held `txEn` plus `data` and consumes per-byte `busy`/`done`, exactly as if it owned the core. The arbiter grants the core for a whole message and rotates priority round-robin between messages. A watchdog reclaims the core from a requester that stalls.

## Interface

- `TIMEOUT`, default 2_000_000 — the maximum number of clk cycles allowed between grant (or the last `coreDone`) and the next `coreDone` before the grant is forcibly revoked. Legal range is ≥ 4.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset: asynchronous, active-high.
- `reqEn`  in  3  per-requester `txEn`. Bit 0 is the formatter, bit 1 is echo, bit 2 is the message path. The level stays high for the whole message.
- `reqData0`, `reqData1`, `reqData2`  in  8 each  per-requester byte.
- `reqBusy`  out  3  per-requester view of core busy.
- `reqDone`  out  3  per-requester view of core done (1-cycle pulse).
- `coreBusy`  in  1  busy from the UART Tx core.
- `coreDone`  in  1  done from the UART Tx core; a 1-cycle pulse at the end of each byte.
- `txEn`  out  1  enable to the core.
- `data`  out  8  byte to the core.
- `grant`  out  3  one-hot index of the current owner; all zeros when there is no owner.
- `timeoutErr`  out  1  1-cycle pulse when the watchdog revokes a grant.

## Operation

**States (registered): IDLE, GRANT, RELEASE.** Registered state also includes `grant[2:0]`, round-robin pointer `ptr[1:0]` (values 0..2), and watchdog counter `wdt` of width $clog2(TIMEOUT+1).

**IDLE**
- If `reqEn != 0` and `!coreBusy`, select the first set bit searching `ptr`, `ptr+1`, `ptr+2` (mod 3).
- Load `grant` with the one-hot of that bit, clear `wdt`, and go to GRANT.
- Otherwise stay in IDLE.

**GRANT** (let g be the granted index)
- If `reqEn[g] == 0`: go to RELEASE and set `ptr = (g+1) mod 3`.
- Else if `wdt == TIMEOUT-1` and `coreDone == 0`: go to RELEASE, set `ptr = (g+1) mod 3`, and pulse `timeoutErr` for 1 cycle.
- Else: on `coreDone` clear `wdt`; otherwise increment `wdt`, saturating.

**RELEASE**
- `txEn` is forced to 0.
- When `!coreBusy`, clear `grant` and go to IDLE.

**Output muxing (combinational from registered state)**
- `txEn = (state==GRANT) & reqEn[g]`.
- `data = reqData[g]` in GRANT; 8'h00 otherwise.
- `reqDone[i] = coreDone & grant[i] & (state==GRANT)`.
- `reqBusy[i] = coreBusy` if `grant[i]`, or if `state==IDLE`.
- `reqBusy[i] = 1` for every non-granted requester while the state is GRANT or RELEASE. Blocked sources therefore hold off their start.

**Ownership and bytes**
- A revoked requester that keeps `reqEn` high is treated as a new request once the state is back in IDLE. Because `ptr` has advanced, other pending requesters are served first.
- The arbiter never alters bytes. Message content and order within a message are the requester's responsibility.

## Timing

- Reset values: state=IDLE, `grant`=0, `ptr`=0, `wdt`=0, `txEn`=0, `data`=8'h00, `reqDone`=0, `timeoutErr`=0. `reqBusy` equals `coreBusy` on all three bits.
- Request latency: `reqEn[i]` rises at edge k with the core idle → `grant`/`txEn` are high after edge k+1 (1 cycle).
- Release: `reqEn[g]` falls → RELEASE at the next edge. IDLE follows one edge after `coreBusy` is low. The earliest new grant is therefore at least 2 edges after the fall, so back-to-back messages from different requesters have a ≥ 2-cycle `txEn`-low gap.
- Simultaneous requests in IDLE: exactly one grant, by the round-robin order above. The others stay pending with `reqBusy=1`.
- `reqEn[g]` falling in the same cycle as `coreDone`: `reqDone[g]` is still delivered, and the state goes to RELEASE.
- Timeout and `coreDone` in the same cycle: `coreDone` wins, and the counter clears.
- Reset mid-message: everything returns to reset values immediately. On exit from reset, IDLE waits until any in-flight byte completes (`coreBusy` low) before granting.

## Test plan

- **Single requester.** Drive `reqEn`=3'b001 with `reqData0`=8'h41 and model 2 bytes; drop `reqEn` after the second `coreDone`.
  - Required: `grant`=001 one cycle later; `data`=8'h41; `reqDone[0]` pulses twice; `grant`=000 once `coreBusy` is low.
- **Round-robin.** Hold `reqEn`=3'b111 continuously, with each requester ending its message after 1 byte.
  - Required: grant order 001, 010, 100, 001. Each grant is preceded by ≥ 2 cycles of `txEn`=0.
- **Blocking.** While requester 0 is granted, raise `reqEn[2]`.
  - Required: `reqBusy[2]`=1 and `reqDone[2]`=0 until requester 0 releases, then `grant`=100.
- **Watchdog.** Use `TIMEOUT`=16. Grant requester 1 with the core model never asserting `coreDone`.
  - Required: `timeoutErr` pulses exactly 16 cycles after the grant; the state goes to RELEASE; `ptr`=2.
- **Reset mid-message.** Assert `rst` asynchronously during byte 3 of a message.
  - Required: all outputs reach their reset values immediately. After release, no grant occurs while `coreBusy`=1.
- **Edge coincidence.** Drop `reqEn[0]` in the same cycle as `coreDone`.
  - Required: `reqDone[0]` pulses, followed by an orderly release.
